cfu_cmd_issuer: RTL

CPU-side initiator for the CFU command/response interface. It accepts a "dot-product job" consisting of a packed filter word and a word count N. It then drives the CFU through one SET_FILTER command and N SIMD-MAC commands, pulling input words from a valid/ready stream. The signed 32-bit responses are accumulated and the sum is presented on a result handshake. It replaces software loops in bring-up benches and DMA-driven inference paths, and sits between a data mover and the CFU ports.

---
 rtl/cfu_pkg.sv | 24 ++
 rtl/cfu_rsp_timer.sv | 30 +++
 rtl/cfu_cmd_issuer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cfu_pkg.sv
// Shared CFU command encodings and issuer state encoding.
// Function IDs are {funct7, funct3}; only SET_FILTER and MAC are issued by this block.
package cfu_pkg;

    localparam int FUNCT7_W = 7;
    localparam int FUNCT3_W = 3;
    localparam int FID_W    = FUNCT7_W + FUNCT3_W;

    localparam logic [FID_W-1:0] FID_NOP        = 10'd0;
    localparam logic [FID_W-1:0] FID_MAC        = {7'd0, 3'd1};
    localparam logic [FID_W-1:0] FID_CLR_FILTER = 10'd8;
    localparam logic [FID_W-1:0] FID_SET_FILTER = {7'd1, 3'd1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLT_CMD,
        ST_FLT_RSP,
        ST_FETCH,
        ST_MAC_CMD,
        ST_MAC_RSP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cfu_rsp_timer.sv
// Response watchdog: cleared when a command is accepted, counts cycles without rsp_valid.
// expire is combinational and fires on the cycle whose increment would reach TIMEOUT_CYCLES.
// No backpressure; count_en is gated by the caller.
module cfu_rsp_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic count_en,
    output logic expire
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    // Firing one count early lands the DONE transition exactly TIMEOUT_CYCLES after acceptance.
    assign expire = count_en && (cnt == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cfu_cmd_issuer.sv
// Dot-product job engine: one SET_FILTER then N MAC commands to the CFU, summing the responses.
// Latency: 2 + 3N + 1 cycles minimum from job accept to res_valid (CFU and data always ready).
// Backpressure: holds commands until cmd_ready, waits in FETCH for data, holds result until res_ready.
module cfu_cmd_issuer
    import cfu_pkg::*;
#(
    parameter int COUNT_W        = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [31:0]        job_filter,
    input  logic [COUNT_W-1:0] job_count,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic [31:0]        data_word,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_sum,
    output logic               res_error,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [FID_W-1:0]   cmd_payload_function_id,
    output logic [31:0]        cmd_payload_inputs_0,
    output logic [31:0]        cmd_payload_inputs_1,
    input  logic               rsp_valid,
    output logic               rsp_ready,
    input  logic [31:0]        rsp_payload_outputs_0
);

    state_t             state, state_nxt;
    logic [31:0]        filter_q;
    logic [31:0]        word_q;
    logic [31:0]        acc;
    logic [COUNT_W-1:0] remaining;
    logic               in_rsp;
    logic               to_expire;

    assign in_rsp = (state == ST_FLT_RSP) || (state == ST_MAC_RSP);

    cfu_rsp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cmd_valid && cmd_ready),
        .count_en(in_rsp && !rsp_valid),
        .expire  (to_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (job_valid) state_nxt = ST_FLT_CMD;
            ST_FLT_CMD: if (cmd_ready) state_nxt = ST_FLT_RSP;
            ST_FLT_RSP: begin
                if (rsp_valid) begin
                    state_nxt = (remaining == '0) ? ST_DONE : ST_FETCH;
                end else if (to_expire) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_FETCH:   if (data_valid) state_nxt = ST_MAC_CMD;
            ST_MAC_CMD: if (cmd_ready) state_nxt = ST_MAC_RSP;
            ST_MAC_RSP: begin
                if (rsp_valid) begin
                    state_nxt = (remaining == COUNT_W'(1)) ? ST_DONE : ST_FETCH;
                end else if (to_expire) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:    if (res_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        job_ready               = 1'b0;
        data_ready              = 1'b0;
        res_valid               = 1'b0;
        rsp_ready               = 1'b0;
        cmd_valid               = 1'b0;
        cmd_payload_function_id = FID_NOP;
        cmd_payload_inputs_0    = 32'd0;
        case (state)
            ST_IDLE: begin
                job_ready = 1'b1;
                rsp_ready = 1'b1;
            end
            ST_FLT_CMD: begin
                cmd_valid               = 1'b1;
                cmd_payload_function_id = FID_SET_FILTER;
                cmd_payload_inputs_0    = filter_q;
            end
            ST_FLT_RSP: rsp_ready = 1'b1;
            ST_FETCH:   data_ready = 1'b1;
            ST_MAC_CMD: begin
                cmd_valid               = 1'b1;
                cmd_payload_function_id = FID_MAC;
                cmd_payload_inputs_0    = word_q;
            end
            ST_MAC_RSP: rsp_ready = 1'b1;
            ST_DONE:    res_valid = 1'b1;
            default:    ;
        endcase
    end

    assign cmd_payload_inputs_1 = 32'd0;
    assign res_sum              = acc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filter_q  <= '0;
            word_q    <= '0;
            acc       <= '0;
            remaining <= '0;
            res_error <= 1'b0;
        end else begin
            if (state == ST_IDLE && job_valid) begin
                filter_q  <= job_filter;
                remaining <= job_count;
                acc       <= '0;
                res_error <= 1'b0;
            end
            if (state == ST_FETCH && data_valid) begin
                word_q <= data_word;
            end
            if (state == ST_MAC_RSP && rsp_valid) begin
                acc       <= acc + rsp_payload_outputs_0;
                remaining <= remaining - COUNT_W'(1);
            end
            // A response in the expiry cycle takes priority, so only flag a silent expiry.
            if (in_rsp && to_expire) begin
                res_error <= 1'b1;
            end
        end
    end

endmodule
